// File: rtl/seg_sched_pkg.sv
// Shared types, segment table and helpers for seg_display_scheduler.
package seg_sched_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } sched_state_t;

    // Segments a..g in bits 7..1; bit 0 (dot) is always clear here and filled by the decoder.
    localparam logic [7:0] HexSeg [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2,
        8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E,
        8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    function automatic logic [1:0] gnt_of(input sched_state_t s);
        case (s)
            StOwn0:  return 2'b01;
            StOwn1:  return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-high abcdefgh decoder with dot and blanking.
module seg_hex_decoder
    import seg_sched_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dot,
    input  logic       i_blank,
    output logic [7:0] o_abcdefgh
);

    logic [7:0] w_pattern;

    assign w_pattern  = HexSeg[i_nibble];
    // A blanked digit still shows its dot.
    assign o_abcdefgh = i_blank ? {7'b0, i_dot} : (w_pattern | {7'b0, i_dot});

endmodule

// File: rtl/seg_display_scheduler.sv
// Multiplexed 7-segment scheduler: two requesters share the display, switched round-robin per frame.
// Optional leading-zero blanking is enabled by defining SEG_SCHED_ZERO_BLANK_EN.
module seg_display_scheduler
    import seg_sched_pkg::*;
#(
    parameter int unsigned clk_mhz      = 50,
    parameter int unsigned w_digit      = 8,
    parameter int unsigned digit_cycles = clk_mhz * 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req,
    input  logic [4*w_digit-1:0]   value0,
    input  logic [4*w_digit-1:0]   value1,
    input  logic [w_digit-1:0]     dots0,
    input  logic [w_digit-1:0]     dots1,
    output logic [1:0]             gnt,
    output logic [7:0]             abcdefgh,
    output logic [w_digit-1:0]     digit
);

    localparam int unsigned PresW = (digit_cycles > 1) ? $clog2(digit_cycles) : 1;
    localparam int unsigned IdxW  = $clog2(w_digit);
    localparam logic [PresW-1:0] PresLast = PresW'(digit_cycles - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(w_digit - 1);

    logic [PresW-1:0]     r_presc;
    logic [IdxW-1:0]      r_idx;
    sched_state_t         r_state;
    logic [1:0]           r_gnt;
    logic [4*w_digit-1:0] r_snap_value;
    logic [w_digit-1:0]   r_snap_dots;
    logic [w_digit-1:0]   r_digit;
    logic [7:0]           r_seg;

    logic                 w_tick;
    logic                 w_last;
    sched_state_t         w_state_d;
    logic [IdxW-1:0]      w_idx_d;
    logic                 w_take;
    logic [3:0]           w_nibble;
    logic                 w_dot;
    logic                 w_blank;
    logic [7:0]           w_seg;
    logic [w_digit-1:0]   w_onehot;

    assign w_tick = (r_presc == PresLast);
    assign w_last = (r_idx == IdxLast);

    // Ownership only changes on a tick; while owned, only on the frame-closing tick.
    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_take    = 1'b0;
        if (w_tick) begin
            w_idx_d = w_last ? '0 : r_idx + IdxW'(1);
            case (r_state)
                StIdle: begin
                    if (req != 2'b00) begin
                        w_state_d = req[0] ? StOwn0 : StOwn1;
                        w_idx_d   = '0;
                        w_take    = 1'b1;
                    end
                end
                StOwn0: begin
                    if (w_last) begin
                        if (req[1]) begin
                            w_state_d = StOwn1;
                        end else if (!req[0]) begin
                            w_state_d = StIdle;
                        end
                        w_take = (req != 2'b00);
                    end
                end
                StOwn1: begin
                    if (w_last) begin
                        if (req[0]) begin
                            w_state_d = StOwn0;
                        end else if (!req[1]) begin
                            w_state_d = StIdle;
                        end
                        w_take = (req != 2'b00);
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_state      <= StIdle;
            r_gnt        <= 2'b00;
            r_snap_value <= '0;
            r_snap_dots  <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PresW'(1);
            r_idx   <= w_idx_d;
            r_state <= w_state_d;
            r_gnt   <= gnt_of(w_state_d);
            if (w_take) begin
                r_snap_value <= (w_state_d == StOwn1) ? value1 : value0;
                r_snap_dots  <= (w_state_d == StOwn1) ? dots1 : dots0;
            end
        end
    end

    assign w_nibble = r_snap_value[4*r_idx +: 4];
    assign w_dot    = r_snap_dots[r_idx];
    assign w_onehot = {{(w_digit - 1){1'b0}}, 1'b1} << r_idx;

`ifdef SEG_SCHED_ZERO_BLANK_EN
    logic [w_digit-1:0] w_lead_zero;
    logic               w_run_zero;

    // Digit i is a leading zero when it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        w_lead_zero = '0;
        w_run_zero  = 1'b1;
        for (int i = int'(w_digit) - 1; i >= 1; i--) begin
            w_run_zero     = w_run_zero & (r_snap_value[4*i +: 4] == 4'h0);
            w_lead_zero[i] = w_run_zero;
        end
    end

    assign w_blank = w_lead_zero[r_idx];
`else
    assign w_blank = 1'b0;
`endif

    seg_hex_decoder u_hex_decoder (
        .i_nibble   (w_nibble),
        .i_dot      (w_dot),
        .i_blank    (w_blank),
        .o_abcdefgh (w_seg)
    );

    always_ff @(posedge clk) begin
        if (rst || (r_state == StIdle)) begin
            r_digit <= '0;
            r_seg   <= '0;
        end else begin
            r_digit <= w_onehot;
            r_seg   <= w_seg;
        end
    end

    assign gnt      = r_gnt;
    assign digit    = r_digit;
    assign abcdefgh = r_seg;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Self-checking bench for seg_display_scheduler (4 digits, 4 clocks per digit) against a behavioural model.
module tb_seg_display_scheduler;

    localparam int W  = 4;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [15:0] value0 = '0;
    logic [15:0] value1 = '0;
    logic [3:0]  dots0 = '0;
    logic [3:0]  dots1 = '0;
    logic [1:0]  gnt;
    logic [7:0]  abcdefgh;
    logic [3:0]  digit;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          m_cnt = 0;
    int          m_pos = 0;
    int          m_owner = -1;
    logic [15:0] m_sval = '0;
    logic [3:0]  m_sdots = '0;
    logic [1:0]  m_gnt = '0;
    logic [3:0]  m_digit = '0;
    logic [7:0]  m_seg = '0;

    string SEG_LETTERS [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                                "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    always #5 clk = ~clk;

    seg_display_scheduler #(
        .clk_mhz      (50),
        .w_digit      (W),
        .digit_cycles (DC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .value0   (value0),
        .value1   (value1),
        .dots0    (dots0),
        .dots1    (dots1),
        .gnt      (gnt),
        .abcdefgh (abcdefgh),
        .digit    (digit)
    );

    function automatic logic [7:0] seg_of(input int n);
        logic [7:0] s;
        string t;
        s = 8'h00;
        t = SEG_LETTERS[n];
        for (int k = 0; k < t.len(); k++) s[7 - (int'(t[k]) - 97)] = 1'b1;
        return s;
    endfunction

    function automatic logic [7:0] disp_of(input logic [15:0] val, input logic [3:0] dts, input int pos);
        int nib;
        bit blank;
        nib = int'((val >> (4 * pos)) & 16'hF);
        blank = 1'b0;
`ifdef SEG_SCHED_ZERO_BLANK_EN
        blank = (pos > 0) && ((val >> (4 * pos)) == 16'h0);
`endif
        return blank ? {7'b0, dts[pos]} : (seg_of(nib) | {7'b0, dts[pos]});
    endfunction

    task automatic model_take();
        m_sval  = (m_owner == 1) ? value1 : value0;
        m_sdots = (m_owner == 1) ? dots1 : dots0;
    endtask

    task automatic model_edge();
        bit tick;
        if (rst) begin
            m_cnt = 0; m_pos = 0; m_owner = -1; m_sval = '0; m_sdots = '0;
            m_digit = '0; m_seg = '0;
        end else begin
            if (m_owner < 0) begin
                m_digit = '0;
                m_seg   = '0;
            end else begin
                m_digit = 4'(1 << m_pos);
                m_seg   = disp_of(m_sval, m_sdots, m_pos);
            end
            tick  = (m_cnt == DC - 1);
            m_cnt = tick ? 0 : m_cnt + 1;
            if (tick) begin
                if (m_owner < 0) begin
                    if (req != 2'b00) begin
                        m_owner = req[0] ? 0 : 1;
                        m_pos = 0;
                        model_take();
                    end else begin
                        m_pos = (m_pos + 1) % W;
                    end
                end else if (m_pos == W - 1) begin
                    if (req[1 - m_owner]) m_owner = 1 - m_owner;
                    else if (!req[m_owner]) m_owner = -1;
                    m_pos = 0;
                    if (m_owner >= 0) model_take();
                end else begin
                    m_pos = m_pos + 1;
                end
            end
        end
        m_gnt = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00;
        step();
        n_cmp++;
        if ({gnt, digit, abcdefgh} !== 14'b0) begin
            n_bad++;
            $display("FAIL reset_state: got gnt=%b digit=%b seg=%h, want all zero", gnt, digit, abcdefgh);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            value0 = 16'($urandom()); value1 = 16'($urandom());
            dots0 = 4'($urandom()); dots1 = 4'($urandom());
            step();
            n_cmp++;
            if ({gnt, digit, abcdefgh} !== 14'b0 || m_gnt !== 2'b00) begin
                n_bad++;
                $display("FAIL idle_no_req c=%0d: got gnt=%b digit=%b seg=%h, want all zero",
                         c, gnt, digit, abcdefgh);
            end
        end
    endtask

    task automatic test_single_owner();
        logic [3:0] ed [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [7:0] es [4] = '{8'h66, 8'hF2, 8'hDA, 8'h60};
        int k;
        do_reset();
        req = 2'b01; value0 = 16'h1234; dots0 = 4'b0000; value1 = 16'h5678;
        k = 0;
        while (gnt == 2'b00 && k < 20) begin step(); k++; end
        n_cmp++;
        if (gnt !== 2'b01 || k !== 4) begin
            n_bad++;
            $display("FAIL first_grant: got gnt=%b after %0d clocks, want 01 after 4", gnt, k);
        end
        for (int s = 0; s < 16; s++) begin
            step();
            n_cmp++;
            if ({digit, abcdefgh} !== {ed[s/4], es[s/4]}) begin
                n_bad++;
                $display("FAIL walk_1234 s=%0d: got digit=%b seg=%h, want digit=%b seg=%h",
                         s, digit, abcdefgh, ed[s/4], es[s/4]);
            end
            n_cmp++;
            if ({gnt, digit, abcdefgh} !== {m_gnt, m_digit, m_seg}) begin
                n_bad++;
                $display("FAIL walk_model s=%0d: got gnt=%b digit=%b seg=%h, want gnt=%b digit=%b seg=%h",
                         s, gnt, digit, abcdefgh, m_gnt, m_digit, m_seg);
            end
        end
    endtask

    task automatic test_round_robin();
        int k;
        logic [1:0] eg;
        do_reset();
        req = 2'b11; value0 = 16'($urandom()); value1 = 16'($urandom());
        dots0 = 4'($urandom()); dots1 = 4'($urandom());
        k = 0;
        while (gnt == 2'b00 && k < 20) begin step(); k++; end
        n_cmp++;
        if (gnt !== 2'b01) begin
            n_bad++;
            $display("FAIL rr_first: got gnt=%b, want 01", gnt);
        end
        for (int s = 1; s < 64; s++) begin
            step();
            eg = (((s / 16) % 2) == 0) ? 2'b01 : 2'b10;
            n_cmp++;
            if (gnt !== eg || {digit, abcdefgh} !== {m_digit, m_seg}) begin
                n_bad++;
                $display("FAIL rr_alternate s=%0d: got gnt=%b digit=%b seg=%h, want gnt=%b digit=%b seg=%h",
                         s, gnt, digit, abcdefgh, eg, m_digit, m_seg);
            end
        end
    endtask

    task automatic test_no_tearing();
        int k;
        do_reset();
        req = 2'b01; value0 = 16'h1234; dots0 = 4'b0000;
        k = 0;
        while (gnt == 2'b00 && k < 20) begin step(); k++; end
        for (int s = 1; s <= 32; s++) begin
            step();
            if (s == 6) value0 = 16'hABCD;
            n_cmp++;
            if ({gnt, digit, abcdefgh} !== {m_gnt, m_digit, m_seg}) begin
                n_bad++;
                $display("FAIL tear_model s=%0d: got gnt=%b digit=%b seg=%h, want gnt=%b digit=%b seg=%h",
                         s, gnt, digit, abcdefgh, m_gnt, m_digit, m_seg);
            end
            if (s == 16 || s == 17 || s == 32) begin
                n_cmp++;
                if (abcdefgh !== ((s == 16) ? 8'h60 : ((s == 17) ? 8'h7A : 8'hEE))) begin
                    n_bad++;
                    $display("FAIL tear_frame s=%0d: got seg=%h, want %h", s, abcdefgh,
                             (s == 16) ? 8'h60 : ((s == 17) ? 8'h7A : 8'hEE));
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int k;
        do_reset();
        req = 2'b01; value0 = 16'h9F3C; dots0 = 4'b0101;
        k = 0;
        while (gnt == 2'b00 && k < 20) begin step(); k++; end
        for (int s = 0; s < 9; s++) step();
        rst = 1'b1;
        step();
        n_cmp++;
        if ({gnt, digit, abcdefgh} !== 14'b0) begin
            n_bad++;
            $display("FAIL midframe_reset: got gnt=%b digit=%b seg=%h, want all zero", gnt, digit, abcdefgh);
        end
        rst = 1'b0;
        k = 0;
        while (gnt == 2'b00 && k < 20) begin step(); k++; end
        n_cmp++;
        if (gnt !== 2'b01 || k !== 4) begin
            n_bad++;
            $display("FAIL regrant: got gnt=%b after %0d clocks, want 01 after 4", gnt, k);
        end
    endtask

    task automatic test_zero_blank();
        logic [7:0] es [4];
        int k;
`ifdef SEG_SCHED_ZERO_BLANK_EN
        es = '{8'hFC, 8'hB6, 8'h00, 8'h00};
`else
        es = '{8'hFC, 8'hB6, 8'hFC, 8'hFC};
`endif
        do_reset();
        req = 2'b01; value0 = 16'h0050; dots0 = 4'b0000;
        k = 0;
        while (gnt == 2'b00 && k < 20) begin step(); k++; end
        for (int s = 0; s < 16; s++) begin
            step();
            n_cmp++;
            if (abcdefgh !== es[s/4] || digit !== 4'(1 << (s / 4))) begin
                n_bad++;
                $display("FAIL zero_blank s=%0d: got digit=%b seg=%h, want digit=%b seg=%h",
                         s, digit, abcdefgh, 4'(1 << (s / 4)), es[s/4]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) req = 2'($urandom());
            if ($urandom_range(0, 7) == 0) value0 = 16'($urandom() >> $urandom_range(0, 16));
            if ($urandom_range(0, 7) == 0) value1 = 16'($urandom() >> $urandom_range(0, 16));
            if ($urandom_range(0, 7) == 0) dots0 = 4'($urandom());
            if ($urandom_range(0, 7) == 0) dots1 = 4'($urandom());
            rst = ($urandom_range(0, 399) == 0);
            step();
            n_cmp++;
            if ({gnt, digit, abcdefgh} !== {m_gnt, m_digit, m_seg}) begin
                n_bad++;
                $display("FAIL random c=%0d: got gnt=%b digit=%b seg=%h, want gnt=%b digit=%b seg=%h",
                         c, gnt, digit, abcdefgh, m_gnt, m_digit, m_seg);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_owner();
        test_round_robin();
        test_no_tearing();
        test_reset_mid_frame();
        test_zero_blank();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
